// File: rtl/showdown_scheduler.sv
// Sequences one shared hand comparator over the active seats (champion vs. next challenger).
// Define SHOWDOWN_TIMEOUT_EN to add a comparator watchdog of TIMEOUT_CYCLES cycles.
module showdown_scheduler #(
  parameter int NUM_PLAYERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CARD_W         = 6
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     start_i,
  input  logic [NUM_PLAYERS-1:0]                   active_i,
  input  logic [NUM_PLAYERS-1:0][1:0][CARD_W-1:0]  hole_i,
  input  logic [4:0][CARD_W-1:0]                   community_i,
  output logic                                     cmp_start_o,
  output logic [1:0][CARD_W-1:0]                   cmp_player1_o,
  output logic [1:0][CARD_W-1:0]                   cmp_player2_o,
  output logic [4:0][CARD_W-1:0]                   cmp_community_o,
  input  logic                                     cmp_winner_i,
  input  logic                                     cmp_draw_i,
  input  logic                                     cmp_valid_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [NUM_PLAYERS-1:0]                   winners_o,
  output logic                                     no_contest_o,
  output logic                                     timeout_o
);

  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [NUM_PLAYERS-1:0] SEAT0 = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_e;

  state_e                                  state_q, state_d;
  logic [IDX_W-1:0]                        champ_q, champ_d, chal_q, chal_d;
  logic [NUM_PLAYERS-1:0]                  winners_q, winners_d;
  logic                                    no_contest_q, no_contest_d;
  logic                                    res_win_q, res_win_d, res_draw_q, res_draw_d;
  logic [NUM_PLAYERS-1:0]                  snap_act_q;
  logic [NUM_PLAYERS-1:0][1:0][CARD_W-1:0] snap_hole_q;
  logic [4:0][CARD_W-1:0]                  snap_comm_q;
  logic                                    load_snap;
  logic [IDX_W:0]                          first_s, second_s, next_s;

  // Lowest set bit of mask strictly above 'from' (or at 'from' when incl); MSB = found.
  function automatic logic [IDX_W:0] next_set(input logic [NUM_PLAYERS-1:0] mask,
                                              input logic [IDX_W-1:0] from,
                                              input logic incl);
    logic             found;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from)) || (incl && (i == int'(from))))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    return {found, idx};
  endfunction

  assign load_snap = (state_q == S_IDLE) && start_i;
  assign first_s   = next_set(snap_act_q, '0, 1'b1);
  assign second_s  = next_set(snap_act_q, first_s[IDX_W-1:0], 1'b0);
  assign next_s    = next_set(snap_act_q, chal_q, 1'b0);

`ifdef SHOWDOWN_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    champ_d      = champ_q;
    chal_d       = chal_q;
    winners_d    = winners_q;
    no_contest_d = no_contest_q;
    res_win_d    = res_win_q;
    res_draw_d   = res_draw_q;
`ifdef SHOWDOWN_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          winners_d    = '0;
          no_contest_d = 1'b0;
`ifdef SHOWDOWN_TIMEOUT_EN
          timeout_d    = 1'b0;
`endif
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        champ_d = first_s[IDX_W-1:0];
        chal_d  = second_s[IDX_W-1:0];
        if (!first_s[IDX_W]) begin
          no_contest_d = 1'b1;
          winners_d    = '0;
          state_d      = S_DONE;
        end else begin
          winners_d = SEAT0 << first_s[IDX_W-1:0];
          state_d   = second_s[IDX_W] ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
`ifdef SHOWDOWN_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cmp_valid_i) begin
          res_win_d  = cmp_winner_i;
          res_draw_d = cmp_draw_i;
          state_d    = S_UPDATE;
        end
`ifdef SHOWDOWN_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          winners_d = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_UPDATE: begin
        // A draw adds the challenger to the pot; the lower seat stays champion.
        if (res_draw_q) begin
          winners_d = winners_q | (SEAT0 << chal_q);
        end else if (res_win_q) begin
          champ_d   = chal_q;
          winners_d = SEAT0 << chal_q;
        end
        if (next_s[IDX_W]) begin
          chal_d  = next_s[IDX_W-1:0];
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      champ_q      <= '0;
      chal_q       <= '0;
      winners_q    <= '0;
      no_contest_q <= 1'b0;
      res_win_q    <= 1'b0;
      res_draw_q   <= 1'b0;
      snap_act_q   <= '0;
      snap_hole_q  <= '0;
      snap_comm_q  <= '0;
    end else begin
      state_q      <= state_d;
      champ_q      <= champ_d;
      chal_q       <= chal_d;
      winners_q    <= winners_d;
      no_contest_q <= no_contest_d;
      res_win_q    <= res_win_d;
      res_draw_q   <= res_draw_d;
      if (load_snap) begin
        snap_act_q  <= active_i;
        snap_hole_q <= hole_i;
        snap_comm_q <= community_i;
      end
    end
  end

`ifdef SHOWDOWN_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign busy_o          = (state_q == S_SETUP) || (state_q == S_ISSUE) ||
                           (state_q == S_WAIT)  || (state_q == S_UPDATE);
  assign done_o          = (state_q == S_DONE);
  assign cmp_start_o     = (state_q == S_ISSUE);
  assign cmp_player1_o   = snap_hole_q[champ_q];
  assign cmp_player2_o   = snap_hole_q[chal_q];
  assign cmp_community_o = snap_comm_q;
  assign winners_o       = winners_q;
  assign no_contest_o    = no_contest_q;

endmodule

// File: doc/showdown_scheduler.md
Name: showdown_scheduler

Overview:
- Sequences the shared `hand_comparator` across up to NUM_PLAYERS seats to resolve a multi-way showdown.
- Runs a king-of-the-hill sweep: the current champion is always compared against the next active challenger.
- Accumulates a one-hot or multi-hot winners mask, so split pots are reported.
- Sits between the game FSM, which issues `start`, and the single comparator instance.

Parameters:
- NUM_PLAYERS, 4, number of seats (2..8).
- TIMEOUT_CYCLES, 1024, comparator watchdog limit; used only with SHOWDOWN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a showdown
- active  in  NUM_PLAYERS  seat still in hand (not folded)
- hole  in  card_t[NUM_PLAYERS][2]  hole cards per seat
- community  in  card_t[5]  board cards
- cmp_start  out  1  one-cycle start pulse to hand_comparator
- cmp_player1  out  card_t[2]  champion hole cards
- cmp_player2  out  card_t[2]  challenger hole cards
- cmp_community  out  card_t[5]  latched board
- cmp_winner  in  1  0 = player1 wins, 1 = player2 wins
- cmp_draw  in  1  tie
- cmp_valid  in  1  comparator result valid
- busy  out  1  showdown in progress
- done  out  1  one-cycle completion pulse
- winners  out  NUM_PLAYERS  seats sharing the pot; held until next start
- no_contest  out  1  active was all-zero at start
- timeout  out  1  watchdog abort (SHOWDOWN_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- One clock `clk`; reset `reset_n` is synchronous and active-low.
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - busy, done, cmp_start, no_contest, timeout = 0; winners = 0.
  - Aborts any showdown in progress; a comparator result arriving later is ignored.
- IDLE:
  - On start=1, snapshot active, hole and community into internal registers. Later input changes have no effect.
  - Clear winners, no_contest and timeout.
  - busy=1; go to SETUP.
- SETUP (1 cycle):
  - champ = lowest set bit of the active snapshot; chal = next set bit above champ.
  - No active bit: no_contest=1, winners=0 → DONE.
  - Exactly one active bit: winners = 1<<champ → DONE. No comparator traffic.
  - Otherwise: winners = 1<<champ → ISSUE.
- ISSUE (1 cycle):
  - cmp_start=1.
  - cmp_player1 = hole[champ]; cmp_player2 = hole[chal]; cmp_community = snapshot.
  - Next state WAIT.
- cmp_player*/cmp_community hold stable from ISSUE through WAIT.
- hand_comparator drops winner_valid the cycle after start, so any cmp_valid level seen before the WAIT state is stale and is never sampled.
- WAIT:
  - Stay while cmp_valid=0.
  - On cmp_valid=1, register the result → UPDATE.
- UPDATE (1 cycle):
  - cmp_draw=1: winners |= 1<<chal; champ unchanged.
  - Else cmp_winner=1: champ = chal; winners = 1<<chal.
  - Else: no change.
  - Then chal = next active seat above chal. None left → DONE; else → ISSUE.
- DONE (1 cycle): done=1, busy=0 → IDLE.
- Outputs winners and no_contest stay valid until the next accepted start.
- start while busy=1 is ignored; no queueing.
- Latency:
  - k active seats, k≥2: (k−1) comparisons.
  - Each comparison costs ISSUE + comparator latency + UPDATE.
  - Add 1 cycle for SETUP and 1 for DONE.
- Seat indices are $clog2(NUM_PLAYERS) bits wide. Scans are priority encoders over the snapshot mask; there is no wrap-around.

Optional Feature:
- Macro SHOWDOWN_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES-1 without cmp_valid sets timeout=1 and winners=0, then goes to DONE (done pulses).
  - timeout holds until the next accepted start or reset.
- Undefined:
  - WAIT blocks indefinitely; timeout is tied 0.
  - The counter is not synthesized.

Test Plan:
- 2 seats, active=0b11:
  - Stimulus: P0 {6H,2C}, P1 {AH,3D}; board {2H,3H,4H,5H,4S}.
  - Response: one cmp_start pulse → winners=0b01, done pulses once, no_contest=0.
- 4 seats, active=0b1011:
  - Stimulus: P0 pair, P1 two pair, P3 full house; P2 holds a royal flush but has folded.
  - Response: exactly 2 comparisons, (0,1) then (1,3) → winners=0b1000. Seat 2 is never placed on cmp_player*.
- 3-way split:
  - Stimulus: board {AS,KS,QS,JS,TS} royal flush, active=0b0111.
  - Response: both comparisons return draw → winners=0b0111.
- Degenerate masks:
  - active=0b0000 → no_contest=1, winners=0, done 2 cycles after start, cmp_start never pulses.
  - active=0b0100 → winners=0b0100, no cmp_start.
- Robustness:
  - start re-asserted while busy → ignored, result unchanged.
  - reset_n=0 during WAIT → all outputs 0 next cycle; a late cmp_valid produces no done.
  - Hole inputs changed after start → result matches the snapshot.
- SHOWDOWN_TIMEOUT_EN with TIMEOUT_CYCLES=16:
  - Stimulus: comparator model never asserts cmp_valid.
  - Response: timeout=1 and done pulse 16 cycles after WAIT entry, winners=0.
  - Without the macro: busy stays 1.
